shift_right_pipe: RTL and testbench

SHIFT_RIGHT_PIPE -- requirements
Module: shift_right_pipe

---
 rtl/shift_right_pipe.sv | 130 +++++++++++++
 tb/tb_shift_right_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_pipe.sv
// shift_right_pipe: two-stage valid/ready pipeline that moves every symbol of a
// vector toward the MSB end by `shift` symbol positions. Vacated low-order
// symbols take `fill`. A shift larger than MAX_SHIFT yields an all-fill vector
// with out_err set.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready combinational from out_ready)
//   in_data [VW]            symbol vector, symbol 0 in the MSBs
//   shift [3], fill [SW]    shift amount and fill symbol, sampled with in_data
//   out_valid/out_ready     output handshake
//   out_data [VW], out_err  shifted vector and illegal-shift flag
//   xfer_count, err_count   saturating 16-bit statistics (only with
//                           SHIFT_RIGHT_PIPE_STATS_EN defined)
module shift_right_pipe #(
  parameter int unsigned SYMBOL_WIDTH = 12,
  parameter int unsigned NUM_SYMBOLS  = 8,
  parameter int unsigned MAX_SHIFT    = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SYMBOL_WIDTH*NUM_SYMBOLS-1:0] in_data,
  input  logic [2:0]                          shift,
  input  logic [SYMBOL_WIDTH-1:0]             fill,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SYMBOL_WIDTH*NUM_SYMBOLS-1:0] out_data,
  output logic                                out_err
`ifdef SHIFT_RIGHT_PIPE_STATS_EN
  ,
  output logic [15:0]                         xfer_count,
  output logic [15:0]                         err_count
`endif
);

  localparam int unsigned SW  = SYMBOL_WIDTH;
  localparam int unsigned NUM = NUM_SYMBOLS;
  localparam int unsigned VW  = SW * NUM;

  // Stage 1: captured inputs
  logic          r_s1_valid;
  logic [VW-1:0] r_s1_data;
  logic [2:0]    r_s1_shift;
  logic [SW-1:0] r_s1_fill;

  // Stage 2: computed result
  logic          r_s2_valid;
  logic [VW-1:0] r_out_data;
  logic          r_out_err;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic [VW-1:0] w_res;
  logic          w_err;

  // A stage may load when it is empty or its content leaves this cycle.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  // Symbol k takes symbol k+shift; positions past the end take fill.
  // An illegal shift leaves every position at fill.
  always_comb begin
    w_err = (32'(r_s1_shift) > MAX_SHIFT);
    w_res = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      w_res[SW*(NUM-1-k) +: SW] = r_s1_fill;
      if (!w_err && ((k + 32'(r_s1_shift)) < NUM)) begin
        w_res[SW*(NUM-1-k) +: SW] = r_s1_data[SW*(NUM-1-k-32'(r_s1_shift)) +: SW];
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shift <= '0;
      r_s1_fill  <= '0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data  <= in_data;
          r_s1_shift <= shift;
          r_s1_fill  <= fill;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_res;
          r_out_err  <= w_err;
        end
      end
    end
  end

`ifdef SHIFT_RIGHT_PIPE_STATS_EN
  logic [15:0] r_xfer_count;
  logic [15:0] r_err_count;
  logic        w_out_xfer;

  assign w_out_xfer = r_s2_valid && out_ready;
  assign xfer_count = r_xfer_count;
  assign err_count  = r_err_count;

  // Saturating output-transfer and error counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
      r_err_count  <= '0;
    end else if (w_out_xfer) begin
      if (r_xfer_count != 16'hFFFF) r_xfer_count <= r_xfer_count + 16'd1;
      if (r_out_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_right_pipe.sv
// Self-checking bench for shift_right_pipe: directed cases, back-pressure,
// reset flush and randomized traffic against a symbol-queue reference model.
module tb_shift_right_pipe;

  localparam int unsigned SW   = 12;
  localparam int unsigned NUM  = 8;
  localparam int unsigned VW   = SW * NUM;
  localparam int unsigned MAXS = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [2:0]    shift;
  logic [SW-1:0] fill;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          out_err;
`ifdef SHIFT_RIGHT_PIPE_STATS_EN
  logic [15:0]   xfer_count;
  logic [15:0]   err_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [VW-1:0] d;
    logic          e;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];

  shift_right_pipe #(.SYMBOL_WIDTH(SW), .NUM_SYMBOLS(NUM), .MAX_SHIFT(MAXS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shift     (shift),
    .fill      (fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef SHIFT_RIGHT_PIPE_STATS_EN
    ,
    .xfer_count(xfer_count),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: list of symbols, drop s from the front, append s fills.
  function automatic xfer_t ref_model(input logic [VW-1:0] d, input logic [2:0] s,
                                      input logic [SW-1:0] f);
    logic [SW-1:0] q[$];
    xfer_t r;
    for (int k = 0; k < int'(NUM); k++) q.push_back(d[VW-1-SW*k -: SW]);
    if (int'(s) > int'(MAXS)) begin
      r.e = 1'b1;
      q.delete();
      for (int k = 0; k < int'(NUM); k++) q.push_back(f);
    end else begin
      r.e = 1'b0;
      for (int i = 0; i < int'(s); i++) begin
        void'(q.pop_front());
        q.push_back(f);
      end
    end
    r.d = '0;
    for (int k = 0; k < int'(NUM); k++) r.d = {r.d[VW-SW-1:0], q[k]};
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(VW) / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Recorder: expected results of accepted inputs, and observed outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_data, shift, fill));
      if (out_valid && out_ready) obs_q.push_back(xfer_t'({out_data, out_err}));
    end
  end

  // Present one vector and hold it until accepted (bounded).
  task automatic push_vec(input logic [VW-1:0] d, input logic [2:0] s, input logic [SW-1:0] f);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d; shift = s; fill = f;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL push_timeout: in_ready got=0 required=1 within 100 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = rand_vec(); shift = 3'd2; fill = 12'hABC;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h required=0", out_data); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b required=0", out_err); end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignore_in_valid got=%b required=0", out_valid); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = {8{12'h123}}; shift = 3'd0; fill = 12'h456;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready got=%b required=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b required=0", out_valid); end
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_out_valid got=%b required=1", out_valid); end
    total++; if (out_data !== {8{12'h123}}) begin bad++; $display("FAIL lat_out_data got=%h required=%h", out_data, {8{12'h123}}); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL lat_out_err got=%b required=0", out_err); end
  endtask

  task automatic test_directed();
    xfer_t req[3];
    pulse_reset();
    out_ready = 1'b1;
    req[0] = xfer_t'({96'h333_444_555_666_777_DEF_DEF_DEF, 1'b0});
    req[1] = xfer_t'({{8{12'h456}}, 1'b1});
    req[2] = xfer_t'({{8{12'h456}}, 1'b1});
    push_vec(96'h000_111_222_333_444_555_666_777, 3'd3, 12'hDEF);
    push_vec(rand_vec(), 3'd6, 12'h456);
    push_vec(rand_vec(), 3'd7, 12'h456);
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL dir_count got=%0d required=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== req[i]) begin
        bad++; $display("FAIL dir_vec%0d got=%h/%b required=%h/%b", i, obs_q[i].d, obs_q[i].e, req[i].d, req[i].e);
      end
    end
`ifdef SHIFT_RIGHT_PIPE_STATS_EN
    total++; if (xfer_count !== 16'd3) begin bad++; $display("FAIL dir_xfer_count got=%0d required=3", xfer_count); end
    total++; if (err_count !== 16'd2) begin bad++; $display("FAIL dir_err_count got=%0d required=2", err_count); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    int outs = 0;
    int bubbles = 0;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8); in_data = rand_vec(); shift = 3'($urandom_range(0, 7)); fill = 12'($urandom);
      @(negedge clk);
      if (i < 8 && in_ready !== 1'b1) bubbles++;
      if (i >= 2 && out_valid === 1'b1) outs++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (bubbles != 0) begin bad++; $display("FAIL tput_in_bubbles got=%0d required=0", bubbles); end
    total++; if (outs != 8) begin bad++; $display("FAIL tput_out_beats got=%0d required=8", outs); end
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL tput_count got=%0d required=8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL tput_vec%0d got=%h/%b required=%h/%b", i, obs_q[i].d, obs_q[i].e, exp_q[i].d, exp_q[i].e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] vd[10];
    logic [2:0]    vs[10];
    logic [SW-1:0] vf[10];
    xfer_t         want;
    int            sent = 0;
    bit            stalled = 1'b0;
    bit            saw_block = 1'b0;
    logic [VW-1:0] held_d = '0;
    logic          held_e = 1'b0;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      vd[i] = rand_vec(); vs[i] = 3'($urandom_range(0, 7)); vf[i] = 12'($urandom);
    end
    for (int t = 0; t < 40; t++) begin
      out_ready = !(t >= 3 && t <= 6);
      in_valid  = (sent < 10);
      if (sent < 10) begin in_data = vd[sent]; shift = vs[sent]; fill = vf[sent]; end
      @(negedge clk);
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_err !== held_e) begin
          bad++; $display("FAIL b2b_hold t=%0d got=%b/%h/%b required=1/%h/%b", t, out_valid, out_data, out_err, held_d, held_e);
        end
      end
      stalled = out_valid && !out_ready;
      held_d = out_data; held_e = out_err;
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (!saw_block) begin bad++; $display("FAIL b2b_in_ready_fall got=never required=low while stalled"); end
    total++; if (obs_q.size() != 10) begin bad++; $display("FAIL b2b_count got=%0d required=10", obs_q.size()); end
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      want = ref_model(vd[i], vs[i], vf[i]);
      total++;
      if (obs_q[i] !== want) begin
        bad++; $display("FAIL b2b_vec%0d got=%h/%b required=%h/%b", i, obs_q[i].d, obs_q[i].e, want.d, want.e);
      end
    end
  endtask

  task automatic test_random();
    exp_q.delete(); obs_q.delete();
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = rand_vec();
      shift     = 3'($urandom_range(0, 7));
      fill      = 12'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_vec%0d got=%h/%b required=%h/%b", i, obs_q[i].d, obs_q[i].e, exp_q[i].d, exp_q[i].e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0;
    push_vec(rand_vec(), 3'd1, 12'h111);
    push_vec(rand_vec(), 3'd2, 12'h222);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_full got=ready%b/valid%b required=ready0/valid1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_data = rand_vec(); shift = 3'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b required=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b required=1", in_ready); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_ghost got=%0d required=0", obs_q.size()); end
    @(posedge clk); #1;
  endtask

`ifdef SHIFT_RIGHT_PIPE_STATS_EN
  task automatic test_saturate();
    pulse_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = rand_vec(); shift = 3'd0; fill = 12'h0;
    repeat (65545) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (xfer_count !== 16'hFFFF) begin bad++; $display("FAIL sat_xfer_count got=%h required=ffff", xfer_count); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL sat_err_count got=%h required=0", err_count); end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_throughput();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef SHIFT_RIGHT_PIPE_STATS_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
